vector_reduce_unit: RTL and testbench

- Downstream consumer of the element-wise vector ALU's registered result vector `S[N-1:0]`.
- Folds all N elements into one BITS-wide scalar: sum, signed max, signed min, or XOR.
- Processes one element per clock, so the ALU datapath does not need an N-input combinational tree.
- The scalar result is returned to the host HAL, or fed back as the ALU `scalar` operand.

---
 rtl/vector_reduce_unit.sv | 177 +++++++++++++++++
 tb/tb_vector_reduce_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_reduce_unit.sv
// vector_reduce_unit
//
// Folds an N-element vector into one BITS-wide scalar, one element per
// clock: wrapping sum, signed max, signed min or bitwise XOR. The vector
// and the op are captured when `start` is accepted in IDLE. Then RUN
// consumes elements 1..N-1, and DONE raises `done` for one cycle.
//
// Optional feature macro: REDUCE_SATURATE_EN
//   When defined, the sum saturates as a signed value at every step.
//   A sticky `sat` output reports whether any step clamped.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous, active-high reset
//   vec          in   [BITS-1:0] x [N-1:0] vector, sampled on accepted start
//   op           in   2-bit reduction select (00 sum, 01 max, 10 min, 11 xor)
//   start        in   request, accepted only in IDLE
//   busy         out  high while in RUN
//   done         out  one-cycle pulse while in DONE
//   result       out  accumulator; holds until the next accepted start
//   sat          out  sticky clamp flag (only with REDUCE_SATURATE_EN)
//   dbg_state_o  out  current FSM state, for observation only
//
// Handshake: there is no back-pressure. A `start` seen outside IDLE is
// dropped. `done` is not held for an acknowledge.

module vector_reduce_unit #(
    parameter int BITS = 8,
    parameter int N    = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BITS-1:0] vec [N-1:0],
    input  logic [1:0]      op,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [BITS-1:0] result,
`ifdef REDUCE_SATURATE_EN
    output logic            sat,
`endif
    output logic [1:0]      dbg_state_o
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_SUM = 2'b00;
    localparam logic [1:0] OP_MAX = 2'b01;
    localparam logic [1:0] OP_MIN = 2'b10;

    state_t          state_q, state_d;
    logic [BITS-1:0] vec_q [N-1:0];
    logic [BITS-1:0] acc_q, acc_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [1:0]      op_q, op_d;
    logic            load;
    logic [BITS-1:0] elem;
    logic [BITS-1:0] step_val;

`ifdef REDUCE_SATURATE_EN
    logic            sat_q, sat_d;
    logic            step_sat;
    logic [BITS:0]   sum_ext;
`else
    logic [BITS-1:0] sum_wrap;
`endif

    assign elem = vec_q[idx_q];

    // One accumulation step. On ties max/min keep acc.
    always_comb begin
        step_val = acc_q ^ elem;
`ifdef REDUCE_SATURATE_EN
        step_sat = 1'b0;
        // Sign-extend by one bit; the top two bits differing means overflow.
        sum_ext  = {acc_q[BITS-1], acc_q} + {elem[BITS-1], elem};
`else
        sum_wrap = acc_q + elem;
`endif
        case (op_q)
            OP_SUM: begin
`ifdef REDUCE_SATURATE_EN
                if (sum_ext[BITS] != sum_ext[BITS-1]) begin
                    step_sat = 1'b1;
                    step_val = sum_ext[BITS] ? {1'b1, {(BITS-1){1'b0}}}
                                             : {1'b0, {(BITS-1){1'b1}}};
                end else begin
                    step_val = sum_ext[BITS-1:0];
                end
`else
                step_val = sum_wrap;
`endif
            end
            OP_MAX:  step_val = ($signed(elem) > $signed(acc_q)) ? elem : acc_q;
            OP_MIN:  step_val = ($signed(elem) < $signed(acc_q)) ? elem : acc_q;
            default: step_val = acc_q ^ elem;
        endcase
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        op_d    = op_q;
        load    = 1'b0;
`ifdef REDUCE_SATURATE_EN
        sat_d   = sat_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    acc_d   = vec[0];
                    idx_d   = IW'(1);
                    op_d    = op;
`ifdef REDUCE_SATURATE_EN
                    sat_d   = 1'b0;
`endif
                    state_d = (N > 1) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                acc_d = step_val;
                idx_d = idx_q + IW'(1);
`ifdef REDUCE_SATURATE_EN
                sat_d = sat_q | step_sat;
`endif
                if (idx_q == IW'(N - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            op_q    <= '0;
`ifdef REDUCE_SATURATE_EN
            sat_q   <= 1'b0;
`endif
            for (int i = 0; i < N; i++) begin
                vec_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
`ifdef REDUCE_SATURATE_EN
            sat_q   <= sat_d;
`endif
            if (load) begin
                vec_q <= vec;
            end
        end
    end

    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign result      = acc_q;
    assign dbg_state_o = state_q;
`ifdef REDUCE_SATURATE_EN
    assign sat         = sat_q;
`endif

endmodule

// File: tb/tb_vector_reduce_unit.sv
module tb_vector_reduce_unit;

    localparam int BITS = 8;
    localparam int N    = 64;

    // ---------------- clock / reset ----------------
    logic            clk = 1'b0;
    logic            rst;
    logic [BITS-1:0] vec [N-1:0];
    logic [1:0]      op;
    logic            start;
    logic            busy;
    logic            done;
    logic [BITS-1:0] result;
    logic [1:0]      dbg_state;
`ifdef REDUCE_SATURATE_EN
    logic            sat;
`endif

    always #5 clk = ~clk;

    vector_reduce_unit #(.BITS(BITS), .N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .vec         (vec),
        .op          (op),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .result      (result),
`ifdef REDUCE_SATURATE_EN
        .sat         (sat),
`endif
        .dbg_state_o (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [BITS-1:0] exp_q[$];
    bit              sexp_q[$];
    logic [BITS-1:0] stim [N-1:0];
    int              n_vec = 0;
    int              n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Works on integers: fold the whole stimulus array by the op rule.
    function automatic logic [BITS-1:0] model(input logic [1:0] o, output bit s);
        int acc;
        int v;
        int maxv;
        int minv;
        maxv = (1 << (BITS - 1)) - 1;
        minv = -(1 << (BITS - 1));
        s    = 1'b0;
        acc  = int'($signed(stim[0]));
        for (int i = 1; i < N; i++) begin
            v = int'($signed(stim[i]));
            case (o)
                2'b00: begin
                    acc = acc + v;
`ifdef REDUCE_SATURATE_EN
                    if (acc > maxv) begin acc = maxv; s = 1'b1; end
                    if (acc < minv) begin acc = minv; s = 1'b1; end
`endif
                end
                2'b01: if (v > acc) acc = v;
                2'b10: if (v < acc) acc = v;
                default: acc = acc ^ v;
            endcase
        end
        return acc[BITS-1:0];
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_done: done=1 with no pending op, result=0x%0h (t=%0t)", result, $time);
            end else begin
                logic [BITS-1:0] e;
                bit              es;
                e  = exp_q.pop_front();
                es = sexp_q.pop_front();
                chk("result", int'(result), int'(e));
`ifdef REDUCE_SATURATE_EN
                chk("sat", int'(sat), int'(es));
`endif
            end
        end
    end

    // ---------------- driver ----------------
    // late_at >= 0: re-pulse start (new vec) at that RUN cycle, and again in DONE.
    task automatic run_op(input logic [1:0] o, input int late_at, input bit scramble);
        bit              es;
        logic [BITS-1:0] e;
        int              cyc;
        int              busy_cnt;
        e = model(o, es);
        exp_q.push_back(e);
        sexp_q.push_back(es);
        @(negedge clk);
        vec   = stim;
        op    = o;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (scramble) begin
            for (int i = 0; i < N; i++) vec[i] = BITS'($urandom);
            op = 2'($urandom);
        end
        cyc      = 0;
        busy_cnt = 0;
        while (!done && cyc < N + 20) begin
            if (busy) busy_cnt++;
            if (cyc == late_at) begin
                start = 1'b1;
                for (int i = 0; i < N; i++) vec[i] = BITS'($urandom);
                op = 2'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("latency", cyc, N - 1);
        chk("busy_cycles", busy_cnt, N - 1);
        chk("busy_in_done", int'(busy), 0);
        if (late_at >= 0) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_pulse_width", int'(done), 0);
        @(negedge clk);
        chk("idle_after_done", int'(busy), 0);
        chk("result_held", int'(result), int'(e));
    endtask

    task automatic fill(input logic [BITS-1:0] val);
        for (int i = 0; i < N; i++) stim[i] = val;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst   = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        for (int i = 0; i < N; i++) vec[i] = '0;

        // Asynchronous reset, checked before any clock edge.
        #3 rst = 1'b1;
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_result", int'(result), 0);
        chk("reset_state", int'(dbg_state), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Ramp sum.
        for (int i = 0; i < N; i++) stim[i] = BITS'(i);
        run_op(2'b00, -1, 1'b0);
`ifndef REDUCE_SATURATE_EN
        chk("t1_ramp_sum", int'(result), 'hE0);
`endif

        // Signed max/min with extremes.
        fill(8'h05);
        stim[10] = 8'h7F;
        stim[40] = 8'h80;
        run_op(2'b01, -1, 1'b0);
        chk("t2_max", int'(result), 'h7F);
        run_op(2'b10, -1, 1'b0);
        chk("t2_min", int'(result), 'h80);

        // XOR with vec/op scrambled right after start.
        fill(8'h01);
        run_op(2'b11, -1, 1'b1);
        chk("t3_xor", int'(result), 'h00);

        // Start re-pulsed during RUN and DONE is dropped.
        for (int i = 0; i < N; i++) stim[i] = BITS'($urandom);
        run_op(2'b00, 15, 1'b0);

        // Reset in the middle of RUN.
        for (int i = 0; i < N; i++) stim[i] = BITS'($urandom);
        @(negedge clk);
        vec   = stim;
        op    = 2'b00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("t5_busy_before_rst", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_busy", int'(busy), 0);
        chk("t5_done", int'(done), 0);
        chk("t5_result", int'(result), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (N + 4) @(negedge clk);
        chk("t5_stays_idle", int'(busy), 0);
        run_op(2'b01, -1, 1'b0);

        // Saturation corner.
        fill(8'h40);
        run_op(2'b00, -1, 1'b0);
`ifdef REDUCE_SATURATE_EN
        chk("t6_sat_result", int'(result), 'h7F);
        chk("t6_sat_flag", int'(sat), 1);
`else
        chk("t6_wrap_result", int'(result), 'h00);
`endif

        // Randomized operations.
        for (int k = 0; k < 20; k++) begin
            int late;
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 5))
                    0:       stim[i] = 8'h7F;
                    1:       stim[i] = 8'h80;
                    default: stim[i] = BITS'($urandom);
                endcase
            end
            late = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 2)) : -1;
            run_op(2'($urandom), late, 1'($urandom));
        end

        repeat (4) @(negedge clk);
        chk("pending_expectations", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d checks done", n_vec);
        $fatal(1, "watchdog");
    end

endmodule
